// File: rtl/ahb_mem_arbiter_pkg.sv
// Shared types for the AHB-lite memory arbiter: FSM states, HTRANS encodings
// and the requester identifier.
package ahb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

endpackage

// File: rtl/ahb_mem_arbiter_pick.sv
// Winner selection between fetch and load/store, with a saturating streak
// counter that caps consecutive contested load/store wins.
module mem_arb_pick
    import ahb_mem_arbiter_pkg::*;
#(
    parameter int LS_STREAK_MAX = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    arb_en,
    input  logic    if_req,
    input  logic    ls_req,
    output logic    pick_valid,
    output req_id_e pick_id
);

    localparam int STREAK_W = (LS_STREAK_MAX < 1) ? 1 : $clog2(LS_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK_MAX);

    logic [STREAK_W-1:0] streak_q;
    logic                if_turn;

    assign pick_valid = if_req | ls_req;
    assign if_turn    = if_req && ls_req && (streak_q == STREAK_MAX);
    assign pick_id    = (ls_req && !if_turn) ? REQ_LS : REQ_IF;

    // A load/store win with no fetch waiting is uncontested and resets the streak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (arb_en && pick_valid) begin
            if (pick_id == REQ_IF || !if_req) begin
                streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single AHB-lite master port,
// one outstanding transfer at a time.
module ahb_mem_arbiter
    import ahb_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int LS_STREAK_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    arb_state_e        state_q, state_d;
    logic              pick_valid;
    req_id_e           pick_id;
    req_id_e           owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              arb_en;
    logic              xfer_done;

    assign arb_en    = (state_q == ST_IDLE);
    assign xfer_done = (state_q == ST_DATA) && HREADY;

    mem_arb_pick #(
        .LS_STREAK_MAX(LS_STREAK_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .if_req    (if_req),
        .ls_req    (ls_req),
        .pick_valid(pick_valid),
        .pick_id   (pick_id)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        HTRANS  = HTRANS_IDLE;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = we_q;
                if (HREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                HWDATA = we_q ? wdata_q : '0;
                if (HREADY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign HADDR = addr_q;

    // Request capture at arbitration and completion bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= REQ_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            if_gnt  <= 1'b0;
            ls_gnt  <= 1'b0;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            if_gnt  <= 1'b0;
            ls_gnt  <= 1'b0;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            if (arb_en && pick_valid) begin
                owner_q <= pick_id;
                if (pick_id == REQ_LS) begin
                    addr_q  <= ls_addr;
                    we_q    <= ls_we;
                    wdata_q <= ls_wdata;
                    ls_gnt  <= 1'b1;
                end else begin
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    if_gnt  <= 1'b1;
                end
            end
            // HRESP is only meaningful once HREADY completes the data phase.
            if (xfer_done) begin
                err <= HRESP;
                if (!we_q) rdata <= HRDATA;
                if (owner_q == REQ_IF) if_done <= 1'b1;
                else                   ls_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter: expected completions are queued when a
// request is issued and compared when the matching done pulse appears.
module tb_ahb_mem_arbiter;
    import ahb_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_done, ls_gnt, ls_done, err;
    logic [31:0] rdata, HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;

    typedef struct packed {
        req_id_e     id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    ahb_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LS_STREAK_MAX(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_done(ls_done), .rdata(rdata), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_done();
        exp_t e;
        check("sb_has_entry", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("if_done", if_done, (e.id == REQ_IF));
            check("ls_done", ls_done, (e.id == REQ_LS));
            check("err", err, e.err);
            check("rdata", rdata, e.rdata);
        end
    endtask

    task automatic single_load();
        ls_we = 1'b0; ls_addr = 32'h100; HRDATA = 32'hDEADBEEF;
        HREADY = 1'b1; HRESP = 1'b0; ls_req = 1'b1;
        sb.push_back('{REQ_LS, 1'b0, 32'hDEADBEEF});
        step();
        check("ld_gnt", ls_gnt, 1);
        check("ld_htrans", HTRANS, HTRANS_NONSEQ);
        check("ld_haddr", HADDR, 32'h100);
        check("ld_hwrite", HWRITE, 0);
        ls_req = 1'b0;
        step();
        check("ld_data_htrans", HTRANS, HTRANS_IDLE);
        check("ld_no_early_done", ls_done, 0);
        step();
        check_done();
    endtask

    // order bit i set means the i-th grant must go to load/store.
    task automatic run_contention(input int n, input logic [7:0] order);
        int grants = 0;
        int cyc    = 0;
        int last   = 0;
        if_addr = 32'h800; ls_addr = 32'h900; ls_we = 1'b0;
        HRDATA = 32'hC0FFEE00; HREADY = 1'b1; HRESP = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        while ((grants < n || sb.size() != 0) && cyc < 60) begin
            step();
            cyc++;
            check("pulses_exclusive", ($countones({if_gnt, ls_gnt, if_done, ls_done}) <= 1), 1'b1);
            if (if_done || ls_done) check_done();
            if (if_gnt || ls_gnt) begin
                check("grant_order", ls_gnt, order[grants]);
                if (grants > 0) check("grant_spacing", cyc - last, 3);
                last = cyc;
                sb.push_back('{(ls_gnt ? REQ_LS : REQ_IF), 1'b0, 32'hC0FFEE00});
                grants++;
                if (grants == n) begin
                    if_req = 1'b0; ls_req = 1'b0;
                end
            end
        end
        check("contention_complete", grants, n);
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

        // Reset state
        step();
        step();
        check("rst_htrans", HTRANS, HTRANS_IDLE);
        check("rst_hwrite", HWRITE, 0);
        check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_pulses", {if_gnt, ls_gnt, if_done, ls_done}, 4'b0000);
        rst_n = 1'b1;

        // Single load, zero wait states
        single_load();

        // Store with two wait states in the data phase
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h55AA;
        HRDATA = 32'h12345678;
        sb.push_back('{REQ_LS, 1'b0, 32'hDEADBEEF});
        step();
        check("st_gnt", ls_gnt, 1);
        check("st_htrans", HTRANS, HTRANS_NONSEQ);
        check("st_hwrite", HWRITE, 1);
        check("st_haddr", HADDR, 32'h200);
        ls_req = 1'b0; ls_we = 1'b0;
        step();
        check("st_hwdata_0", HWDATA, 32'h55AA);
        check("st_data_htrans", HTRANS, HTRANS_IDLE);
        HREADY = 1'b0;
        step();
        check("st_hwdata_1", HWDATA, 32'h55AA);
        check("st_wait_no_done", ls_done, 0);
        step();
        check("st_hwdata_2", HWDATA, 32'h55AA);
        check("st_wait2_no_done", ls_done, 0);
        HREADY = 1'b1;
        step();
        check_done();
        check("st_hwdata_after", HWDATA, 0);

        // Two-cycle error response on a fetch
        if_req = 1'b1; if_addr = 32'h400;
        sb.push_back('{REQ_IF, 1'b1, 32'hBAD0BAD0});
        step();
        check("er_gnt", if_gnt, 1);
        check("er_haddr", HADDR, 32'h400);
        if_req = 1'b0;
        step();
        HREADY = 1'b0; HRESP = 1'b1;
        step();
        check("er_wait_no_done", if_done, 0);
        check("er_wait_htrans", HTRANS, HTRANS_IDLE);
        HREADY = 1'b1; HRDATA = 32'hBAD0BAD0;
        step();
        check_done();
        HRESP = 1'b0;
        step();
        check("er_idle_htrans", HTRANS, HTRANS_IDLE);
        check("er_idle_no_gnt", {if_gnt, ls_gnt}, 2'b00);

        // Continuous contention: ls, ls, if, ls, ls, if
        run_contention(6, 8'b0001_1011);

        // Reset in the data phase after one contested ls win
        if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'hA00;
        step();
        check("rm_gnt", ls_gnt, 1);
        if_req = 1'b0; ls_req = 1'b0;
        step();
        check("rm_in_data", HTRANS, HTRANS_IDLE);
        rst_n = 1'b0;
        #1;
        check("rm_htrans", HTRANS, HTRANS_IDLE);
        check("rm_rdata", rdata, 0);
        check("rm_haddr", HADDR, 0);
        check("rm_pulses", {if_gnt, ls_gnt, if_done, ls_done}, 4'b0000);
        step();
        check("rm_no_done", {if_done, ls_done}, 2'b00);
        rst_n = 1'b1;
        step();
        check("rm_no_done_after", {if_done, ls_done}, 2'b00);

        // Streak must restart from zero: ls, ls, if
        run_contention(3, 8'b0000_0011);
        single_load();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
